// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtracter: the carry chain is cut into STAGES
// registered segments, with a valid/ready stream handshake, flags and optional saturation.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int SEG = WIDTH / STAGES;

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic inv, input logic cin);
    return {1'b0, x} + {1'b0, y ^ {SEG{inv}}} + {{SEG{1'b0}}, cin};
  endfunction

  // Operation as it enters the final segment.
  logic             li_vld, li_sub, li_sat, li_cy;
  logic [SEG-1:0]   li_a, li_b;
  logic [WIDTH-1:0] li_acc;

  generate
    if (STAGES == 1) begin : g_single
      assign li_vld = in_valid;
      assign li_a   = a;
      assign li_b   = b;
      assign li_sub = sub;
      assign li_sat = sat;
      assign li_cy  = sub;
      assign li_acc = '0;
    end else begin : g_pipe
      localparam int NR = STAGES - 1;

      // Operands are shifted down one segment per stage so the next segment is always in the low bits.
      logic             r_vld [NR];
      logic             r_sub [NR];
      logic             r_sat [NR];
      logic             r_cy  [NR];
      logic [WIDTH-1:0] r_a   [NR];
      logic [WIDTH-1:0] r_b   [NR];
      logic [WIDTH-1:0] r_acc [NR];

      logic             n_vld [NR];
      logic             n_sub [NR];
      logic             n_sat [NR];
      logic             n_cy  [NR];
      logic [WIDTH-1:0] n_a   [NR];
      logic [WIDTH-1:0] n_b   [NR];
      logic [WIDTH-1:0] n_acc [NR];

      logic             x_vld, x_sub, x_sat, x_cy;
      logic [WIDTH-1:0] x_a, x_b, x_acc;
      logic [SEG:0]     x_sum;

      always_comb begin
        x_vld = 1'b0;
        x_sub = 1'b0;
        x_sat = 1'b0;
        x_cy  = 1'b0;
        x_a   = '0;
        x_b   = '0;
        x_acc = '0;
        x_sum = '0;
        for (int k = 0; k < NR; k++) begin
          if (k == 0) begin
            x_vld = in_valid;
            x_a   = a;
            x_b   = b;
            x_sub = sub;
            x_sat = sat;
            x_cy  = sub;
            x_acc = '0;
          end else begin
            x_vld = r_vld[k-1];
            x_a   = r_a[k-1];
            x_b   = r_b[k-1];
            x_sub = r_sub[k-1];
            x_sat = r_sat[k-1];
            x_cy  = r_cy[k-1];
            x_acc = r_acc[k-1];
          end
          x_sum    = seg_add(x_a[SEG-1:0], x_b[SEG-1:0], x_sub, x_cy);
          n_vld[k] = x_vld;
          n_sub[k] = x_sub;
          n_sat[k] = x_sat;
          n_cy[k]  = x_sum[SEG];
          n_a[k]   = x_a >> SEG;
          n_b[k]   = x_b >> SEG;
          n_acc[k] = x_acc | (WIDTH'(x_sum[SEG-1:0]) << (k * SEG));
        end
      end

      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          for (int k = 0; k < NR; k++) begin
            r_vld[k] <= 1'b0;
            r_sub[k] <= 1'b0;
            r_sat[k] <= 1'b0;
            r_cy[k]  <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_acc[k] <= '0;
          end
        end else if (adv) begin
          for (int k = 0; k < NR; k++) begin
            r_vld[k] <= n_vld[k];
            r_sub[k] <= n_sub[k];
            r_sat[k] <= n_sat[k];
            r_cy[k]  <= n_cy[k];
            r_a[k]   <= n_a[k];
            r_b[k]   <= n_b[k];
            r_acc[k] <= n_acc[k];
          end
        end
      end

      assign li_vld = r_vld[NR-1];
      assign li_a   = r_a[NR-1][SEG-1:0];
      assign li_b   = r_b[NR-1][SEG-1:0];
      assign li_sub = r_sub[NR-1];
      assign li_sat = r_sat[NR-1];
      assign li_cy  = r_cy[NR-1];
      assign li_acc = r_acc[NR-1];
    end
  endgenerate

  logic [SEG:0]     top;
  logic [WIDTH-1:0] raw, fin;
  logic             ovf;

  // Overflow is carry-in xor carry-out at the MSB; carry-in is recovered from a^b'^sum.
  always_comb begin
    top = seg_add(li_a, li_b, li_sub, li_cy);
    raw = li_acc | (WIDTH'(top[SEG-1:0]) << (WIDTH - SEG));
    ovf = li_a[SEG-1] ^ li_b[SEG-1] ^ li_sub ^ raw[WIDTH-1] ^ top[SEG];
    fin = raw;
    if (li_sat && ovf)
      fin = li_a[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      s         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
    end else if (adv) begin
      out_valid <= li_vld;
      s         <= fin;
      c         <= top[SEG];
      v         <= ovf;
      z         <= (fin == '0);
      n         <= fin[WIDTH-1];
    end
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined integer adder/subtracter; next generation of the team's 32-bit combinational add/sub unit.
- Splits the WIDTH-bit carry chain into STAGES registered segments, using the same two's-complement trick: s = a + (b xor {W{sub}}) + sub.
- Adds a valid/ready stream handshake, status flags (carry, overflow, zero, negative) and optional signed saturation.
- Feeds the ALU result mux and the multi-cycle datapath, where a full-width carry chain no longer meets timing.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline segments and result latency in cycles; minimum 1. Each segment is WIDTH/STAGES bits.

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  asynchronous active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts operand set this cycle
- a  input  WIDTH  operand a
- b  input  WIDTH  operand b
- sub  input  1  0: s = a+b; 1: s = a-b
- sat  input  1  1: clamp signed overflow to max/min
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  result
- c  output  1  carry out of MSB (sub: 1 = no borrow, i.e. a >= b unsigned)
- v  output  1  signed overflow
- z  output  1  s == 0
- n  output  1  s[WIDTH-1]

Behaviour:
- Reset (clrn low, asynchronous): all stage valid bits, out_valid, s, c, v, z and n go to 0 immediately. In-flight operations are discarded. The data registers also clear to 0.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational). The transfer rule is:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - When adv = 1, every stage register shifts one position. An empty stage shifts as a bubble with valid = 0. Bubbles are not collapsed.
  - When adv = 0, all registers hold. s and flags stay stable while out_valid is high and out_ready is low.
- Latency: a result appears on out_valid exactly STAGES adv-cycles after input transfer. Throughput is 1 result/cycle while out_ready stays high. Order is preserved.
- Stage k (0..STAGES-1) computes segment k:
  - Inputs are a_seg + (b_seg xor sub) + cin, where cin = sub for k = 0 and the registered carry of stage k-1 otherwise.
  - The higher, not-yet-added operand segments, sub, and sat travel with the operation.
  - The lower result segments already computed also travel with it.
- Final stage flags:
  - c = carry out of the top segment.
  - v = carry into MSB xor carry out of MSB.
  - When sat = 1 and v = 1: s = 0111..1 if the true result is positive (a[MSB] = 0 for overflow), else 1000..0. Otherwise s is the raw sum.
  - z and n are computed from the final s, after saturation.
  - c and v always reflect the raw operation; saturation does not clear them.
- STAGES = 1: single registered stage, latency 1, identical flags.
- Simultaneous output accept and input accept in the same cycle is legal and sustains full rate.
- in_valid low while adv is high inserts a bubble.
- Operands a, b, sub and sat are sampled only on input transfer; changes at other times are ignored.
- No combinational path from a or b to s. The only combinational paths are out_ready to in_ready and out_valid to in_ready.

Test Plan:
- WIDTH=32, STAGES=4. Input a=5, b=3, sub=0, out_ready=1. Required: 4 cycles later s=0x00000008, c=0, v=0, z=0, n=0, out_valid pulses 1 cycle.
- Subtract cases:
  - a=3, b=5, sub=1: s=0xFFFFFFFE, c=0, n=1, v=0.
  - a=5, b=5, sub=1: s=0, z=1, c=1.
- Segment carry chain:
  - a=0x00FFFFFF, b=1: s=0x01000000, c=0.
  - a=0xFFFFFFFF, b=1: s=0, c=1, z=1, v=0.
- Overflow and saturation:
  - a=0x7FFFFFFF, b=1, sat=0: s=0x80000000, v=1, n=1.
  - Same with sat=1: s=0x7FFFFFFF, v=1, n=0.
  - a=0x80000000, b=1, sub=1, sat=1: s=0x80000000, v=1, c=1.
- Backpressure: stream 8 back-to-back operations (a=i, b=i, sub=0) and drop out_ready for 3 cycles mid-stream. Required:
  - in_ready low in the same cycles.
  - Outputs 0, 2, 4 .. 14 in order, no loss or duplication, s stable while stalled.
  - 1 result per cycle otherwise.
- Reset mid-operation: assert clrn low between edges with 3 operations in flight. Required:
  - out_valid and s go to 0 without a clock edge.
  - After release, no result appears until a new input is accepted.
  - Repeat the directed cases with STAGES=1 (latency 1) and WIDTH=16, STAGES=2.
